vote_capture: RTL

- Ballot-capture front end that sits directly upstream of the EVM vote counter/result mux.
- Conditions the raw party buttons a, b, c, d and the presiding-officer master_enable: synchronises, debounces, rejects multi-press, and enforces one vote per enable.
- Emits exactly one single-cycle vote strobe with the party identity, which the counter consumes as its count-enable.

---
 rtl/evm_pkg.sv | 31 +++
 rtl/evm_sync2.sv | 26 ++
 rtl/vote_capture.sv | 135 +++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM ballot-capture front end.
package evm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COMMIT  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int         NUM_PARTY = 4;
  localparam logic [1:0] PARTY_A   = 2'd0;
  localparam logic [1:0] PARTY_B   = 2'd1;
  localparam logic [1:0] PARTY_C   = 2'd2;
  localparam logic [1:0] PARTY_D   = 2'd3;

  // Button vectors are ordered {a,b,c,d}, so bit 3 is party A.
  function automatic logic [1:0] party_encode(input logic [NUM_PARTY-1:0] onehot);
    logic [1:0] idx;
    idx = PARTY_A;
    if (onehot[2]) idx = PARTY_B;
    if (onehot[1]) idx = PARTY_C;
    if (onehot[0]) idx = PARTY_D;
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [NUM_PARTY-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/evm_sync2.sv
// Parameterised-width two-flop synchroniser for raw asynchronous inputs.
module evm_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vote_capture.sv
// Ballot capture: synchronise and debounce party buttons, allow one vote per
// officer enable, and emit a single-cycle vote strobe to the counter.
module vote_capture
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ARM_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       master_enable,
  output logic       vote_valid,
  output logic [1:0] vote_party,
  output logic [3:0] vote_onehot,
  output logic       armed,
  output logic       multi_press,
  output logic       timeout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMO_W = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ARM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);

  logic [4:0]           w_sync;
  logic [3:0]           w_s_btn;
  logic                 w_s_me;
  logic                 w_onehot;
  logic                 w_multi;
  logic [CNT_W-1:0]     w_cnt_inc;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [TMO_W-1:0]     r_tmo, w_tmo_nxt;
  logic [3:0]           r_cand, w_cand_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic                 r_multi, w_multi_nxt;

  evm_sync2 #(.WIDTH(5)) u_sync (
    .clk (clk),
    .rst (reset),
    .i_d ({a, b, c, d, master_enable}),
    .o_q (w_sync)
  );

  assign w_s_btn   = w_sync[4:1];
  assign w_s_me    = w_sync[0];
  assign w_onehot  = is_onehot(w_s_btn);
  assign w_multi   = (w_s_btn != '0) && !w_onehot;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // One counter serves both the press debounce (ARMED) and release debounce (RELEASE).
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tmo_nxt     = r_tmo;
    w_cand_nxt    = r_cand;
    w_timeout_nxt = 1'b0;
    w_multi_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt  = '0;
        w_tmo_nxt  = '0;
        w_cand_nxt = '0;
        if (w_s_me) w_state_nxt = ARMED;
      end
      ARMED: begin
        w_tmo_nxt = (r_tmo == TMO_MAX) ? r_tmo : r_tmo + 1'b1;
        if (w_onehot) begin
          if (w_s_btn == r_cand) begin
            w_cnt_nxt = w_cnt_inc;
          end else begin
            w_cand_nxt = w_s_btn;
            w_cnt_nxt  = CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
        // Commit takes priority over an expiry on the same edge.
        if (w_onehot && (w_cnt_nxt == CNT_MAX)) begin
          w_state_nxt = COMMIT;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt   = IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_multi_nxt = w_multi;
        end
      end
      COMMIT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (w_s_btn == '0) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_nxt == CNT_MAX) w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_cand    <= '0;
      r_timeout <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      r_cand    <= w_cand_nxt;
      r_timeout <= w_timeout_nxt;
      r_multi   <= w_multi_nxt;
    end
  end

  assign vote_valid  = (r_state == COMMIT);
  assign vote_party  = vote_valid ? party_encode(r_cand) : 2'd0;
  assign vote_onehot = vote_valid ? r_cand : 4'd0;
  assign armed       = (r_state == ARMED);
  assign multi_press = r_multi;
  assign timeout     = r_timeout;

endmodule
